// File: rtl/slot_fifo_pkg.sv
// Shared types and constants for the slot FIFO read-side arbiter.
package slot_fifo_pkg;

  localparam int SLOT_W        = 3;
  localparam int DEF_BURST_LEN = 4;
  localparam int DEF_ADDR_W    = 11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2
  } state_e;

  // Next round-robin start position after slot idx has been served.
  function automatic logic [SLOT_W-1:0] rr_next(input logic [SLOT_W-1:0] idx, input int n);
    return (int'(idx) >= n - 1) ? '0 : idx + 1'b1;
  endfunction

endpackage

// File: rtl/slot_fifo_arbiter_rr_picker.sv
// Combinational round-robin search: first set bit of eligible at or after rr_ptr.
module rr_picker
  import slot_fifo_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0]      eligible,
  input  logic [SLOT_W-1:0] rr_ptr,
  output logic [SLOT_W-1:0] winner,
  output logic              found
);

  logic [2*N-1:0] rotated;
  int             pos;

  // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    winner  = '0;
    found   = 1'b0;
    pos     = 0;
    rotated = {eligible, eligible} >> rr_ptr;
    for (int i = 0; i < N; i++) begin
      if (!found && rotated[i]) begin
        found = 1'b1;
        pos   = int'(rr_ptr) + i;
        if (pos >= N) pos = pos - N;
        winner = SLOT_W'(pos);
      end
    end
  end

endmodule

// File: rtl/slot_fifo_arbiter.sv
// Round-robin arbiter sharing one FIFO read port among NUM_SLOTS DAC slots.
// Optional per-slot underrun counters when SLOT_UNDERRUN_COUNT_EN is defined.
module slot_fifo_arbiter
  import slot_fifo_pkg::*;
#(
  parameter int NUM_SLOTS = 4,
  parameter int BURST_LEN = DEF_BURST_LEN,
  parameter int ADDR_W    = DEF_ADDR_W
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_SLOTS-1:0]        slot_req,
  input  logic [NUM_SLOTS*ADDR_W-1:0] fifo_addr_in,
  input  logic [NUM_SLOTS*ADDR_W-1:0] fifo_addr_out,
  output logic                        fifo_read,
  output logic [SLOT_W-1:0]           fifo_slot,
  input  logic [7:0]                  fifo_data,
  output logic [NUM_SLOTS-1:0]        slot_grant,
  output logic [7:0]                  slot_data,
  output logic                        slot_data_valid,
  output logic [NUM_SLOTS-1:0]        burst_done
`ifdef SLOT_UNDERRUN_COUNT_EN
  ,
  output logic [NUM_SLOTS*8-1:0]      underrun_count
`endif
);

  localparam int BEAT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [NUM_SLOTS-1:0] ONE = {{(NUM_SLOTS-1){1'b0}}, 1'b1};

  state_e              state, state_nxt;
  logic [BEAT_W-1:0]   beat;
  logic [SLOT_W-1:0]   rr_ptr;
  logic [SLOT_W-1:0]   winner, winner_q;
  logic                found;
  logic                load_grant;
  logic                last_beat;
  logic                fifo_read_d1;
  logic                last_d1;
  logic [NUM_SLOTS-1:0] eligible;
  logic [NUM_SLOTS-1:0] starved;

  // Unsigned subtraction keeps occupancy correct across pointer wrap.
  for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_occ
    logic [ADDR_W-1:0] occ;
    assign occ         = fifo_addr_in[g*ADDR_W +: ADDR_W] - fifo_addr_out[g*ADDR_W +: ADDR_W];
    assign eligible[g] = slot_req[g] && (occ >= ADDR_W'(BURST_LEN));
    assign starved[g]  = slot_req[g] && (occ <  ADDR_W'(BURST_LEN));
  end

  rr_picker #(.N(NUM_SLOTS)) u_picker (
    .eligible (eligible),
    .rr_ptr   (rr_ptr),
    .winner   (winner),
    .found    (found)
  );

  assign last_beat = (beat == BEAT_W'(BURST_LEN - 1));

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    fifo_read  = 1'b0;
    load_grant = 1'b0;
    case (state)
      IDLE: begin
        if (found) begin
          load_grant = 1'b1;
          state_nxt  = READ;
        end
      end
      READ: begin
        fifo_read = 1'b1;
        if (last_beat) state_nxt = DRAIN;
      end
      DRAIN:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      beat            <= '0;
      rr_ptr          <= '0;
      winner_q        <= '0;
      fifo_slot       <= '0;
      slot_grant      <= '0;
      fifo_read_d1    <= 1'b0;
      last_d1         <= 1'b0;
      slot_data       <= '0;
      slot_data_valid <= 1'b0;
      burst_done      <= '0;
    end else begin
      beat <= (state == READ && !last_beat) ? beat + 1'b1 : '0;
      if (load_grant) begin
        winner_q   <= winner;
        fifo_slot  <= winner;
        slot_grant <= ONE << winner;
      end
      if (state == DRAIN) begin
        slot_grant <= '0;
        rr_ptr     <= rr_next(winner_q, NUM_SLOTS);
      end
      // Two-stage pipeline matches the one-cycle FIFO read latency plus the output register.
      fifo_read_d1    <= fifo_read;
      last_d1         <= fifo_read && last_beat;
      slot_data_valid <= fifo_read_d1;
      slot_data       <= fifo_data;
      burst_done      <= last_d1 ? (ONE << winner_q) : '0;
    end
  end

`ifdef SLOT_UNDERRUN_COUNT_EN
  for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_underrun
    logic [7:0] cnt;
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        cnt <= '0;
      end else if (state == IDLE && starved[g] && cnt != 8'hFF) begin
        cnt <= cnt + 1'b1;
      end
    end
    assign underrun_count[g*8 +: 8] = cnt;
  end
`endif

endmodule

// File: tb/tb_slot_fifo_arbiter.sv
// Directed self-checking bench for slot_fifo_arbiter (NUM_SLOTS=4, BURST_LEN=4, ADDR_W=11).
module tb_slot_fifo_arbiter;

  localparam int NS = 4;
  localparam int BL = 4;
  localparam int AW = 11;

  logic           clk = 1'b0;
  logic           reset;
  logic [NS-1:0]  slot_req;
  logic [NS*AW-1:0] fifo_addr_in;
  logic [NS*AW-1:0] fifo_addr_out;
  logic           fifo_read;
  logic [2:0]     fifo_slot;
  logic [7:0]     fifo_data;
  logic [NS-1:0]  slot_grant;
  logic [7:0]     slot_data;
  logic           slot_data_valid;
  logic [NS-1:0]  burst_done;
`ifdef SLOT_UNDERRUN_COUNT_EN
  logic [NS*8-1:0] underrun_count;
`endif

  int checks = 0;
  int errors = 0;

  slot_fifo_arbiter #(.NUM_SLOTS(NS), .BURST_LEN(BL), .ADDR_W(AW)) dut (
    .clk             (clk),
    .reset           (reset),
    .slot_req        (slot_req),
    .fifo_addr_in    (fifo_addr_in),
    .fifo_addr_out   (fifo_addr_out),
    .fifo_read       (fifo_read),
    .fifo_slot       (fifo_slot),
    .fifo_data       (fifo_data),
    .slot_grant      (slot_grant),
    .slot_data       (slot_data),
    .slot_data_valid (slot_data_valid),
    .burst_done      (burst_done)
`ifdef SLOT_UNDERRUN_COUNT_EN
    ,
    .underrun_count  (underrun_count)
`endif
  );

  always #5 clk = ~clk;

  // FIFO model: returns 0xA0 + number of reads served so far, one cycle after fifo_read.
  logic [7:0] rd_cnt;
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_cnt    <= '0;
      fifo_data <= '0;
    end else if (fifo_read) begin
      fifo_data <= 8'hA0 + rd_cnt;
      rd_cnt    <= rd_cnt + 1'b1;
    end
  end

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic set_ptr(input int s, input logic [AW-1:0] wr, input logic [AW-1:0] rd);
    fifo_addr_in[s*AW +: AW]  = wr;
    fifo_addr_out[s*AW +: AW] = rd;
  endtask

  task automatic wait_done(input string tag, input logic [NS-1:0] expected);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (burst_done != '0) break;
    end
    check(tag, 32'(burst_done), 32'(expected));
    slot_req = '0;
  endtask

  logic [NS-1:0] exp_grant_1 [1:7] = '{4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0000, 4'b0000};
  logic          exp_read_1  [1:7] = '{1, 1, 1, 1, 0, 0, 0};
  logic          exp_valid_1 [1:7] = '{0, 0, 1, 1, 1, 1, 0};

  int            ev_time  [8];
  logic [NS-1:0] ev_grant [8];
  int            n_ev;
  logic [NS-1:0] prev_grant;
  logic [NS-1:0] exp_rr [6] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};

  initial begin
    reset         = 1'b0;
    slot_req      = '0;
    fifo_addr_in  = '0;
    fifo_addr_out = '0;
    repeat (2) @(negedge clk);
    check("rst_fifo_read", 32'(fifo_read), 0);
    check("rst_grant",     32'(slot_grant), 0);
    check("rst_valid",     32'(slot_data_valid), 0);
    check("rst_done",      32'(burst_done), 0);
    check("rst_fifo_slot", 32'(fifo_slot), 0);
    check("rst_slot_data", 32'(slot_data), 0);
    reset = 1'b1;
    @(negedge clk);

    // Single request, slot 2, occupancy 8.
    set_ptr(2, 11'd8, 11'd0);
    slot_req = 4'b0100;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      check($sformatf("t1_grant_c%0d", k), 32'(slot_grant), 32'(exp_grant_1[k]));
      check($sformatf("t1_read_c%0d", k),  32'(fifo_read),  32'(exp_read_1[k]));
      check($sformatf("t1_valid_c%0d", k), 32'(slot_data_valid), 32'(exp_valid_1[k]));
      check($sformatf("t1_done_c%0d", k),  32'(burst_done), (k == 6) ? 32'h4 : 32'h0);
      if (k <= 4) check($sformatf("t1_slot_c%0d", k), 32'(fifo_slot), 2);
      if (k >= 3 && k <= 6) check($sformatf("t1_data_c%0d", k), 32'(slot_data), 32'h9D + 32'(k));
      if (k == 6) slot_req = '0;
    end

    // Insufficient data: occupancy one short of a burst, then exactly a burst.
    set_ptr(2, 11'd0, 11'd0);
    set_ptr(0, 11'd3, 11'd0);
    slot_req = 4'b0001;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      check("t2_no_grant", 32'(slot_grant), 0);
    end
    set_ptr(0, 11'd4, 11'd0);
    @(negedge clk);
    check("t2_grant", 32'(slot_grant), 32'h1);
    wait_done("t2_done", 4'b0001);
    set_ptr(0, 11'd0, 11'd0);

    // Pointer wrap: write pointer 2, read pointer 2046 gives occupancy 4.
    set_ptr(3, 11'd2, 11'd2046);
    slot_req = 4'b1000;
    @(negedge clk);
    check("t4_wrap_grant", 32'(slot_grant), 32'h8);
    check("t4_wrap_slot",  32'(fifo_slot), 3);
    wait_done("t4_done", 4'b1000);

    // Reset on the 2nd READ beat; rr_ptr is 0 so slot 1 wins first.
    for (int s = 0; s < NS; s++) set_ptr(s, 11'd100, 11'd0);
    slot_req = 4'b0010;
    @(negedge clk);
    check("t5_grant", 32'(slot_grant), 32'h2);
    @(negedge clk);
    check("t5_read_beat2", 32'(fifo_read), 1);
    reset = 1'b0;
    #1;
    check("t5_async_read",  32'(fifo_read), 0);
    check("t5_async_grant", 32'(slot_grant), 0);
    check("t5_async_valid", 32'(slot_data_valid), 0);
    slot_req = 4'b1111;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("t5_no_done", 32'(burst_done), 0);
      check("t5_no_valid", 32'(slot_data_valid), 0);
    end
    reset = 1'b1;

    // Round robin from slot 0 with all slots requesting continuously.
    n_ev       = 0;
    prev_grant = '0;
    for (int c = 1; c <= 36; c++) begin
      @(negedge clk);
      check("t3_no_done_in_rst", 32'((c == 1) ? burst_done : 4'b0), 0);
      if (slot_grant != '0 && prev_grant == '0 && n_ev < 8) begin
        ev_time[n_ev]  = c;
        ev_grant[n_ev] = slot_grant;
        n_ev++;
      end
      prev_grant = slot_grant;
    end
    slot_req = '0;
    check("t3_num_grants", 32'(n_ev), 6);
    check("t3_first_cycle", 32'(ev_time[0]), 1);
    for (int j = 0; j < 6; j++) begin
      check($sformatf("t3_order_%0d", j), 32'(ev_grant[j]), 32'(exp_rr[j]));
      if (j > 0) check($sformatf("t3_spacing_%0d", j), 32'(ev_time[j] - ev_time[j-1]), 6);
    end
    repeat (8) @(negedge clk);

`ifdef SLOT_UNDERRUN_COUNT_EN
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    for (int s = 0; s < NS; s++) set_ptr(s, 11'd0, 11'd0);
    slot_req = 4'b0010;
    repeat (300) @(negedge clk);
    check("t6_underrun_sat",  32'(underrun_count[15:8]), 255);
    check("t6_underrun_idle", 32'(underrun_count[7:0]), 0);
    check("t6_no_grant",      32'(slot_grant), 0);
    slot_req = '0;
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
